// File: rtl/cnt_seq_checker.sv
// Sequence monitor for a free-running step counter: locks onto value+STEP
// progressions, flags breaks while locked and keeps saturating error/wrap stats.
module cnt_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 2,
  parameter int LOCK_CNT = 3,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_i,
  input  logic              cnt_vld_i,
  input  logic              clr_i,
  output logic              locked_o,
  output logic              err_o,
  output logic [STAT_W-1:0] err_cnt_o,
  output logic [STAT_W-1:0] wrap_cnt_o,
  output logic [WIDTH-1:0]  last_cnt_o,
  output logic [1:0]        state_o
);

  localparam int GR_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
  localparam logic [GR_W-1:0]  LOCK_LAST  = GR_W'(LOCK_CNT - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_r,    state_nxt_s;
  logic [GR_W-1:0]    good_run_r, good_run_nxt_s;
  logic               locked_r,   locked_nxt_s;
  logic               err_r,      err_nxt_s;
  logic [STAT_W-1:0]  err_cnt_r,  err_cnt_nxt_s;
  logic [STAT_W-1:0]  wrap_cnt_r, wrap_cnt_nxt_s;
  logic [WIDTH-1:0]   last_cnt_r, last_cnt_nxt_s;
  logic [WIDTH-1:0]   exp_s;
  logic               match_s;
  logic               wrap_s;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    sat_inc = (v == STAT_MAX) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

  // Expected next value and match/overflow qualifiers
  always_comb begin
    exp_s   = last_cnt_r + STEP_V;
    match_s = (cnt_i == exp_s);
    wrap_s  = match_s && (cnt_i < last_cnt_r);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s    = state_r;
    good_run_nxt_s = good_run_r;
    locked_nxt_s   = locked_r;
    err_nxt_s      = 1'b0;
    err_cnt_nxt_s  = err_cnt_r;
    wrap_cnt_nxt_s = wrap_cnt_r;
    last_cnt_nxt_s = last_cnt_r;
    if (cnt_vld_i) begin
      last_cnt_nxt_s = cnt_i;
      case (state_r)
        HUNT: begin
          state_nxt_s    = SYNC;
          good_run_nxt_s = {GR_W{1'b0}};
          locked_nxt_s   = 1'b0;
        end
        SYNC: begin
          if (match_s) begin
            if (good_run_r == LOCK_LAST) begin
              state_nxt_s    = LOCKED;
              locked_nxt_s   = 1'b1;
              good_run_nxt_s = {GR_W{1'b0}};
            end else begin
              good_run_nxt_s = good_run_r + {{(GR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            good_run_nxt_s = {GR_W{1'b0}};
          end
        end
        LOCKED: begin
          if (match_s) begin
            if (wrap_s) begin
              wrap_cnt_nxt_s = sat_inc(wrap_cnt_r);
            end else begin
              wrap_cnt_nxt_s = wrap_cnt_r;
            end
          end else begin
            // The breaking sample is kept as last_cnt so re-sync starts from it
            err_nxt_s      = 1'b1;
            err_cnt_nxt_s  = sat_inc(err_cnt_r);
            state_nxt_s    = SYNC;
            good_run_nxt_s = {GR_W{1'b0}};
            locked_nxt_s   = 1'b0;
          end
        end
        default: begin
          state_nxt_s    = HUNT;
          good_run_nxt_s = {GR_W{1'b0}};
          locked_nxt_s   = 1'b0;
        end
      endcase
    end else begin
      last_cnt_nxt_s = last_cnt_r;
    end
    if (clr_i) begin
      err_cnt_nxt_s  = {STAT_W{1'b0}};
      wrap_cnt_nxt_s = {STAT_W{1'b0}};
    end else begin
      err_cnt_nxt_s  = err_cnt_nxt_s;
    end
  end

  // State and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= HUNT;
      good_run_r <= {GR_W{1'b0}};
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      err_cnt_r  <= {STAT_W{1'b0}};
      wrap_cnt_r <= {STAT_W{1'b0}};
      last_cnt_r <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      good_run_r <= good_run_nxt_s;
      locked_r   <= locked_nxt_s;
      err_r      <= err_nxt_s;
      err_cnt_r  <= err_cnt_nxt_s;
      wrap_cnt_r <= wrap_cnt_nxt_s;
      last_cnt_r <= last_cnt_nxt_s;
    end
  end

  assign locked_o   = locked_r;
  assign err_o      = err_r;
  assign err_cnt_o  = err_cnt_r;
  assign wrap_cnt_o = wrap_cnt_r;
  assign last_cnt_o = last_cnt_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed self-checking bench for cnt_seq_checker with hand-computed expectations.
module tb_cnt_seq_checker;

  logic       clk;
  logic       reset;
  logic [7:0] cnt;
  logic       cnt_vld;
  logic       clr;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic [7:0] last_cnt;
  logic [1:0] state;

  int vec_cnt;
  int miscmp_cnt;
  logic [7:0] cur;

  cnt_seq_checker #(.WIDTH(8), .STEP(2), .LOCK_CNT(3), .STAT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_i      (cnt),
    .cnt_vld_i  (cnt_vld),
    .clr_i      (clr),
    .locked_o   (locked),
    .err_o      (err),
    .err_cnt_o  (err_cnt),
    .wrap_cnt_o (wrap_cnt),
    .last_cnt_o (last_cnt),
    .state_o    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      miscmp_cnt = miscmp_cnt + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable on return
  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    cnt_vld = v;
    cnt     = d;
    clr     = c;
    @(posedge clk);
    #1;
    cnt_vld = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic lock_1357();
    drive(1'b1, 8'd1, 1'b0);
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd5, 1'b0);
    drive(1'b1, 8'd7, 1'b0);
  endtask

  // Break at cur then relock three steps later; cur ends at the locked value
  task automatic break_relock();
    cur = cur + 8'd3;
    drive(1'b1, cur, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cur = cur + 8'd2;
      drive(1'b1, cur, 1'b0);
    end
  endtask

  initial begin
    vec_cnt    = 0;
    miscmp_cnt = 0;
    reset      = 1'b1;
    cnt        = 8'd0;
    cnt_vld    = 1'b0;
    clr        = 1'b0;
    cur        = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk_eq("rst_state", 32'(state), 32'd0);
    chk_eq("rst_locked", 32'(locked), 32'd0);
    chk_eq("rst_err", 32'(err), 32'd0);
    chk_eq("rst_errcnt", 32'(err_cnt), 32'd0);
    chk_eq("rst_wrapcnt", 32'(wrap_cnt), 32'd0);
    chk_eq("rst_last", 32'(last_cnt), 32'd0);

    // Lock acquisition
    drive(1'b1, 8'd1, 1'b0);
    chk_eq("acq_sync", 32'(state), 32'd1);
    chk_eq("acq_last1", 32'(last_cnt), 32'd1);
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd5, 1'b0);
    chk_eq("acq_notyet", 32'(locked), 32'd0);
    drive(1'b1, 8'd7, 1'b0);
    chk_eq("acq_locked", 32'(locked), 32'd1);
    chk_eq("acq_state", 32'(state), 32'd2);
    chk_eq("acq_err", 32'(err), 32'd0);
    chk_eq("acq_errcnt", 32'(err_cnt), 32'd0);

    // Wrap-around while locked
    do_reset();
    drive(1'b1, 8'd249, 1'b0);
    drive(1'b1, 8'd251, 1'b0);
    drive(1'b1, 8'd253, 1'b0);
    drive(1'b1, 8'd255, 1'b0);
    chk_eq("wrap_locked0", 32'(locked), 32'd1);
    chk_eq("wrap_cnt0", 32'(wrap_cnt), 32'd0);
    drive(1'b1, 8'd1, 1'b0);
    chk_eq("wrap_locked", 32'(locked), 32'd1);
    chk_eq("wrap_cnt", 32'(wrap_cnt), 32'd1);
    chk_eq("wrap_err", 32'(err), 32'd0);
    chk_eq("wrap_last", 32'(last_cnt), 32'd1);

    // Sequence break while locked at 9
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd5, 1'b0);
    drive(1'b1, 8'd7, 1'b0);
    drive(1'b1, 8'd9, 1'b0);
    chk_eq("brk_pre_lock", 32'(locked), 32'd1);
    drive(1'b1, 8'd12, 1'b0);
    chk_eq("brk_err", 32'(err), 32'd1);
    chk_eq("brk_errcnt", 32'(err_cnt), 32'd1);
    chk_eq("brk_locked", 32'(locked), 32'd0);
    chk_eq("brk_state", 32'(state), 32'd1);
    chk_eq("brk_last", 32'(last_cnt), 32'd12);
    drive(1'b0, 8'd0, 1'b0);
    chk_eq("brk_err_1cyc", 32'(err), 32'd0);
    chk_eq("brk_gap_errcnt", 32'(err_cnt), 32'd1);
    drive(1'b1, 8'd14, 1'b0);
    drive(1'b1, 8'd16, 1'b0);
    chk_eq("brk_resync", 32'(state), 32'd1);
    drive(1'b1, 8'd18, 1'b0);
    chk_eq("brk_relock", 32'(locked), 32'd1);
    chk_eq("brk_wrap_kept", 32'(wrap_cnt), 32'd1);

    // Valid gaps in SYNC
    do_reset();
    drive(1'b1, 8'd1, 1'b0);
    for (int g = 0; g < 3; g++) drive(1'b0, 8'd99, 1'b0);
    chk_eq("gap_state", 32'(state), 32'd1);
    chk_eq("gap_last", 32'(last_cnt), 32'd1);
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd5, 1'b0);
    drive(1'b1, 8'd7, 1'b0);
    chk_eq("gap_locked", 32'(locked), 32'd1);
    chk_eq("gap_errcnt", 32'(err_cnt), 32'd0);

    // SYNC mismatch resets good_run without error
    do_reset();
    drive(1'b1, 8'd1, 1'b0);
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd8, 1'b0);
    chk_eq("smm_state", 32'(state), 32'd1);
    chk_eq("smm_err", 32'(err), 32'd0);
    chk_eq("smm_errcnt", 32'(err_cnt), 32'd0);
    chk_eq("smm_last", 32'(last_cnt), 32'd8);
    drive(1'b1, 8'd10, 1'b0);
    drive(1'b1, 8'd12, 1'b0);
    chk_eq("smm_run_reset", 32'(state), 32'd1);
    drive(1'b1, 8'd14, 1'b0);
    chk_eq("smm_relock", 32'(locked), 32'd1);

    // Saturation and clear
    do_reset();
    lock_1357();
    cur = 8'd7;
    for (int b = 0; b < 300; b++) break_relock();
    chk_eq("sat_errcnt", 32'(err_cnt), 32'd255);
    chk_eq("sat_locked", 32'(locked), 32'd1);
    chk_eq("sat_wrapcnt", 32'(wrap_cnt), 32'd0);
    drive(1'b0, 8'd0, 1'b1);
    chk_eq("clr_idle_cnt", 32'(err_cnt), 32'd0);
    chk_eq("clr_idle_state", 32'(state), 32'd2);
    chk_eq("clr_idle_locked", 32'(locked), 32'd1);
    drive(1'b1, cur + 8'd3, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    chk_eq("clr_prebrk_cnt", 32'(err_cnt), 32'd1);
    cur = cur + 8'd3;
    for (int k = 0; k < 3; k++) begin
      cur = cur + 8'd2;
      drive(1'b1, cur, 1'b0);
    end
    chk_eq("clr_relock", 32'(locked), 32'd1);
    drive(1'b1, cur + 8'd3, 1'b1);
    chk_eq("clrbrk_errcnt", 32'(err_cnt), 32'd0);
    chk_eq("clrbrk_err", 32'(err), 32'd1);
    chk_eq("clrbrk_state", 32'(state), 32'd1);
    chk_eq("clrbrk_last", 32'(last_cnt), 32'(cur + 8'd3));

    // Reset mid-operation with err_cnt=5 and wrap_cnt=2
    do_reset();
    lock_1357();
    cur = 8'd7;
    for (int b = 0; b < 5; b++) break_relock();
    for (int s = 0; s < 256; s++) begin
      cur = cur + 8'd2;
      drive(1'b1, cur, 1'b0);
    end
    chk_eq("mid_errcnt", 32'(err_cnt), 32'd5);
    chk_eq("mid_wrapcnt", 32'(wrap_cnt), 32'd2);
    chk_eq("mid_locked", 32'(locked), 32'd1);
    do_reset();
    chk_eq("mid_rst_state", 32'(state), 32'd0);
    chk_eq("mid_rst_locked", 32'(locked), 32'd0);
    chk_eq("mid_rst_err", 32'(err), 32'd0);
    chk_eq("mid_rst_errcnt", 32'(err_cnt), 32'd0);
    chk_eq("mid_rst_wrapcnt", 32'(wrap_cnt), 32'd0);
    chk_eq("mid_rst_last", 32'(last_cnt), 32'd0);
    lock_1357();
    chk_eq("mid_relock", 32'(locked), 32'd1);
    chk_eq("mid_relock_state", 32'(state), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
